// File: rtl/seeg_axil_regs.sv
// AXI4-Lite control/status register file for the SEEG acquisition datapath.
// Latency: write response and read data appear one cycle after the completing handshake.
// Backpressure: one outstanding write and one outstanding read. AW/W/AR are refused while a B or R response is held.
//
// Ports: S_AXI_* is the AXI4-Lite slave (single clock, synchronous active-low reset).
// ctrl_enable, ctrl_soft_rst, chan_mask and sample_div drive the datapath.
// stat_busy, stat_ovf_pulse and frame_count are live status inputs from the datapath.
module seeg_axil_regs #(
    parameter int          ADDR_WIDTH = 8,
    parameter logic [31:0] VERSION    = 32'h0001_0000
) (
    input  logic                  S_AXI_ACLK,
    input  logic                  S_AXI_ARESETN,
    input  logic [ADDR_WIDTH-1:0] S_AXI_AWADDR,
    input  logic [2:0]            S_AXI_AWPROT,
    input  logic                  S_AXI_AWVALID,
    output logic                  S_AXI_AWREADY,
    input  logic [31:0]           S_AXI_WDATA,
    input  logic [3:0]            S_AXI_WSTRB,
    input  logic                  S_AXI_WVALID,
    output logic                  S_AXI_WREADY,
    output logic [1:0]            S_AXI_BRESP,
    output logic                  S_AXI_BVALID,
    input  logic                  S_AXI_BREADY,
    input  logic [ADDR_WIDTH-1:0] S_AXI_ARADDR,
    input  logic [2:0]            S_AXI_ARPROT,
    input  logic                  S_AXI_ARVALID,
    output logic                  S_AXI_ARREADY,
    output logic [31:0]           S_AXI_RDATA,
    output logic [1:0]            S_AXI_RRESP,
    output logic                  S_AXI_RVALID,
    input  logic                  S_AXI_RREADY,
    output logic                  ctrl_enable,
    output logic                  ctrl_soft_rst,
    output logic [31:0]           chan_mask,
    output logic [15:0]           sample_div,
    input  logic                  stat_busy,
    input  logic                  stat_ovf_pulse,
    input  logic [31:0]           frame_count
);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    // rdy_en_q holds all READY outputs low during reset and releases them
    // one cycle after ARESETN deasserts.
    logic                  rdy_en_q;
    logic                  aw_held_q, aw_held_d;
    logic [ADDR_WIDTH-1:0] aw_addr_q, aw_addr_d;
    logic                  w_held_q, w_held_d;
    logic [31:0]           w_data_q, w_data_d;
    logic [3:0]            w_strb_q, w_strb_d;
    logic                  bvalid_q, bvalid_d;
    logic [1:0]            bresp_q, bresp_d;
    logic                  rvalid_q, rvalid_d;
    logic [1:0]            rresp_q, rresp_d;
    logic [31:0]           rdata_q, rdata_d;
    logic                  enable_q, enable_d;
    logic                  soft_rst_q, soft_rst_d;
    logic [31:0]           chan_mask_q, chan_mask_d;
    logic [15:0]           sample_div_q, sample_div_d;
    logic [31:0]           scratch_q, scratch_d;
    logic                  ovf_sticky_q, ovf_sticky_d;

    logic                  aw_hs, w_hs, ar_hs, wr_commit, wr_mapped, rd_mapped, ovf_clr;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [31:0]           wr_data, rd_val;
    logic [3:0]            wr_strb;
    logic [1:0]            wr_resp;

    assign S_AXI_AWREADY = rdy_en_q && !aw_held_q && !bvalid_q;
    assign S_AXI_WREADY  = rdy_en_q && !w_held_q && !bvalid_q;
    assign S_AXI_ARREADY = rdy_en_q && !rvalid_q;
    assign S_AXI_BVALID  = bvalid_q;
    assign S_AXI_BRESP   = bresp_q;
    assign S_AXI_RVALID  = rvalid_q;
    assign S_AXI_RRESP   = rresp_q;
    assign S_AXI_RDATA   = rdata_q;
    assign ctrl_enable   = enable_q;
    assign ctrl_soft_rst = soft_rst_q;
    assign chan_mask     = chan_mask_q;
    assign sample_div    = sample_div_q;

    assign aw_hs = S_AXI_AWVALID && S_AXI_AWREADY;
    assign w_hs  = S_AXI_WVALID && S_AXI_WREADY;
    assign ar_hs = S_AXI_ARVALID && S_AXI_ARREADY;

    // A channel arriving this cycle is used directly so that a write whose
    // AW and W handshake together commits on that same edge.
    assign wr_addr   = aw_held_q ? aw_addr_q : S_AXI_AWADDR;
    assign wr_data   = w_held_q ? w_data_q : S_AXI_WDATA;
    assign wr_strb   = w_held_q ? w_strb_q : S_AXI_WSTRB;
    assign wr_commit = (aw_held_q || aw_hs) && (w_held_q || w_hs);

    assign wr_mapped = ((wr_addr >> 5) == '0) && (wr_addr[4:2] != 3'd7);
    assign rd_mapped = ((S_AXI_ARADDR >> 5) == '0) && (S_AXI_ARADDR[4:2] != 3'd7);

    always_comb begin
        wr_resp = RESP_OKAY;
        if (!wr_mapped) begin
            wr_resp = RESP_DECERR;
        end else if (wr_addr[4:2] == 3'd4 || wr_addr[4:2] == 3'd6) begin
            wr_resp = RESP_SLVERR;
        end
    end

    always_comb begin
        case (S_AXI_ARADDR[4:2])
            3'd0:    rd_val = {31'b0, enable_q};
            3'd1:    rd_val = chan_mask_q;
            3'd2:    rd_val = {16'b0, sample_div_q};
            3'd3:    rd_val = {30'b0, ovf_sticky_q, stat_busy};
            3'd4:    rd_val = frame_count;
            3'd5:    rd_val = scratch_q;
            3'd6:    rd_val = VERSION;
            default: rd_val = 32'b0;
        endcase
    end

    always_comb begin
        aw_held_d    = aw_held_q;
        aw_addr_d    = aw_addr_q;
        w_held_d     = w_held_q;
        w_data_d     = w_data_q;
        w_strb_d     = w_strb_q;
        bvalid_d     = bvalid_q;
        bresp_d      = bresp_q;
        rvalid_d     = rvalid_q;
        rresp_d      = rresp_q;
        rdata_d      = rdata_q;
        enable_d     = enable_q;
        soft_rst_d   = 1'b0;
        chan_mask_d  = chan_mask_q;
        sample_div_d = sample_div_q;
        scratch_d    = scratch_q;
        ovf_clr      = 1'b0;

        if (aw_hs) begin
            aw_held_d = 1'b1;
            aw_addr_d = S_AXI_AWADDR;
        end
        if (w_hs) begin
            w_held_d = 1'b1;
            w_data_d = S_AXI_WDATA;
            w_strb_d = S_AXI_WSTRB;
        end

        if (wr_commit) begin
            aw_held_d = 1'b0;
            w_held_d  = 1'b0;
            bvalid_d  = 1'b1;
            bresp_d   = wr_resp;
            if (wr_mapped) begin
                case (wr_addr[4:2])
                    3'd0: if (wr_strb[0]) begin
                        enable_d   = wr_data[0];
                        soft_rst_d = wr_data[1];
                    end
                    3'd1: for (int b = 0; b < 4; b++) begin
                        if (wr_strb[b]) chan_mask_d[8*b +: 8] = wr_data[8*b +: 8];
                    end
                    3'd2: for (int b = 0; b < 2; b++) begin
                        if (wr_strb[b]) sample_div_d[8*b +: 8] = wr_data[8*b +: 8];
                    end
                    3'd3: ovf_clr = wr_strb[0] && wr_data[1];
                    3'd5: for (int b = 0; b < 4; b++) begin
                        if (wr_strb[b]) scratch_d[8*b +: 8] = wr_data[8*b +: 8];
                    end
                    default: ;
                endcase
            end
        end else if (bvalid_q && S_AXI_BREADY) begin
            bvalid_d = 1'b0;
        end

        // An overflow event in the same cycle as the clear keeps the flag set.
        ovf_sticky_d = stat_ovf_pulse ? 1'b1 : (ovf_clr ? 1'b0 : ovf_sticky_q);

        if (ar_hs) begin
            rvalid_d = 1'b1;
            rresp_d  = rd_mapped ? RESP_OKAY : RESP_DECERR;
            rdata_d  = rd_mapped ? rd_val : 32'b0;
        end else if (rvalid_q && S_AXI_RREADY) begin
            rvalid_d = 1'b0;
        end
    end

    always_ff @(posedge S_AXI_ACLK) begin
        if (!S_AXI_ARESETN) begin
            rdy_en_q     <= 1'b0;
            aw_held_q    <= 1'b0;
            aw_addr_q    <= '0;
            w_held_q     <= 1'b0;
            w_data_q     <= 32'b0;
            w_strb_q     <= 4'b0;
            bvalid_q     <= 1'b0;
            bresp_q      <= 2'b0;
            rvalid_q     <= 1'b0;
            rresp_q      <= 2'b0;
            rdata_q      <= 32'b0;
            enable_q     <= 1'b0;
            soft_rst_q   <= 1'b0;
            chan_mask_q  <= 32'hFFFF_FFFF;
            sample_div_q <= 16'd1;
            scratch_q    <= 32'b0;
            ovf_sticky_q <= 1'b0;
        end else begin
            rdy_en_q     <= 1'b1;
            aw_held_q    <= aw_held_d;
            aw_addr_q    <= aw_addr_d;
            w_held_q     <= w_held_d;
            w_data_q     <= w_data_d;
            w_strb_q     <= w_strb_d;
            bvalid_q     <= bvalid_d;
            bresp_q      <= bresp_d;
            rvalid_q     <= rvalid_d;
            rresp_q      <= rresp_d;
            rdata_q      <= rdata_d;
            enable_q     <= enable_d;
            soft_rst_q   <= soft_rst_d;
            chan_mask_q  <= chan_mask_d;
            sample_div_q <= sample_div_d;
            scratch_q    <= scratch_d;
            ovf_sticky_q <= ovf_sticky_d;
        end
    end

    // PROT and the byte-lane address bits carry no meaning for this map.
    logic unused_ok;
    assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, wr_addr[1:0], S_AXI_ARADDR[1:0]};

endmodule

// File: tb/tb_seeg_axil_regs.sv
// Self-checking bench for seeg_axil_regs: table of single AXI accesses plus
// hand-written sequences for reset, split channels, soft reset pulse,
// W1C race, same-edge read/write and reset during a pending response.
module tb_seeg_axil_regs;

    logic        clk = 1'b0;
    logic        arst_n = 1'b0;
    logic [7:0]  awaddr = 8'h0, araddr = 8'h0;
    logic [2:0]  awprot = 3'b0, arprot = 3'b0;
    logic        awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0, arvalid = 1'b0, rready = 1'b0;
    logic [31:0] wdata = 32'h0;
    logic [3:0]  wstrb = 4'h0;
    logic        awready, wready, bvalid, arready, rvalid;
    logic [1:0]  bresp, rresp;
    logic [31:0] rdata;
    logic        ctrl_enable, ctrl_soft_rst;
    logic [31:0] chan_mask;
    logic [15:0] sample_div;
    logic        stat_busy = 1'b0, stat_ovf_pulse = 1'b0;
    logic [31:0] frame_count = 32'h1234_ABCD;

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    seeg_axil_regs #(.ADDR_WIDTH(8), .VERSION(32'h0001_0000)) dut (
        .S_AXI_ACLK(clk), .S_AXI_ARESETN(arst_n),
        .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
        .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
        .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
        .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(arprot), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
        .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
        .ctrl_enable(ctrl_enable), .ctrl_soft_rst(ctrl_soft_rst),
        .chan_mask(chan_mask), .sample_div(sample_div),
        .stat_busy(stat_busy), .stat_ovf_pulse(stat_ovf_pulse), .frame_count(frame_count)
    );

    typedef struct {
        bit          is_wr;
        logic [7:0]  addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [1:0]  resp;
        logic [31:0] rdata;
    } vec_t;

    vec_t vt[$];

    function automatic vec_t W(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s, input logic [1:0] r);
        vec_t v;
        v.is_wr = 1'b1; v.addr = a; v.data = d; v.strb = s; v.resp = r; v.rdata = 32'h0;
        return v;
    endfunction

    function automatic vec_t R(input logic [7:0] a, input logic [1:0] r, input logic [31:0] rd);
        vec_t v;
        v.is_wr = 1'b0; v.addr = a; v.data = 32'h0; v.strb = 4'h0; v.resp = r; v.rdata = rd;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Called at #1 after a rising edge; returns at #1 after the B handshake edge.
    task automatic axi_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s, output logic [1:0] resp);
        bit got_b = 1'b0;
        resp = 2'bxx;
        awaddr = a; wdata = d; wstrb = s;
        awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
        for (int i = 0; i < 50 && !got_b; i++) begin
            bit awh, wh, bh;
            awh = awvalid && awready;
            wh  = wvalid && wready;
            bh  = bvalid && bready;
            if (bh) resp = bresp;
            @(posedge clk); #1;
            if (awh) awvalid = 1'b0;
            if (wh)  wvalid = 1'b0;
            if (bh)  got_b = 1'b1;
        end
        if (!got_b) begin
            nvec++; nerr++;
            $display("FAIL write_timeout addr %h: got no B response, expected one within 50 cycles", a);
            awvalid = 1'b0; wvalid = 1'b0;
        end
    endtask

    task automatic axi_read(input logic [7:0] a, output logic [1:0] resp, output logic [31:0] d);
        bit got_r = 1'b0;
        resp = 2'bxx; d = 32'hxxxx_xxxx;
        araddr = a; arvalid = 1'b1; rready = 1'b1;
        for (int i = 0; i < 50 && !got_r; i++) begin
            bit arh, rh;
            arh = arvalid && arready;
            rh  = rvalid && rready;
            if (rh) begin resp = rresp; d = rdata; end
            @(posedge clk); #1;
            if (arh) arvalid = 1'b0;
            if (rh)  got_r = 1'b1;
        end
        if (!got_r) begin
            nvec++; nerr++;
            $display("FAIL read_timeout addr %h: got no R response, expected one within 50 cycles", a);
            arvalid = 1'b0;
        end
    endtask

    task automatic rd_chk(input string name, input logic [7:0] a, input logic [31:0] exp);
        logic [1:0]  r;
        logic [31:0] d;
        axi_read(a, r, d);
        chk({name, "_rresp"}, {30'b0, r}, 32'h0);
        chk({name, "_rdata"}, d, exp);
    endtask

    task automatic wr_chk(input string name, input logic [7:0] a, input logic [31:0] d, input logic [3:0] s);
        logic [1:0] r;
        axi_write(a, d, s, r);
        chk({name, "_bresp"}, {30'b0, r}, 32'h0);
    endtask

    initial begin
        logic [1:0]  resp;
        logic [31:0] d;

        // Table: reset values, strobes, error responses, partial writes.
        vt.push_back(R(8'h00, 2'b00, 32'h0000_0000));
        vt.push_back(R(8'h04, 2'b00, 32'hFFFF_FFFF));
        vt.push_back(R(8'h08, 2'b00, 32'h0000_0001));
        vt.push_back(R(8'h0C, 2'b00, 32'h0000_0000));
        vt.push_back(R(8'h10, 2'b00, 32'h1234_ABCD));
        vt.push_back(R(8'h14, 2'b00, 32'h0000_0000));
        vt.push_back(R(8'h18, 2'b00, 32'h0001_0000));
        vt.push_back(W(8'h14, 32'hA5A5_A5A5, 4'hF, 2'b00));
        vt.push_back(W(8'h14, 32'h1234_5678, 4'b0101, 2'b00));
        vt.push_back(R(8'h14, 2'b00, 32'hA534_A578));
        vt.push_back(W(8'h10, 32'h0000_0000, 4'hF, 2'b10));
        vt.push_back(R(8'h10, 2'b00, 32'h1234_ABCD));
        vt.push_back(W(8'h18, 32'hFFFF_FFFF, 4'hF, 2'b10));
        vt.push_back(R(8'h18, 2'b00, 32'h0001_0000));
        vt.push_back(R(8'h1C, 2'b11, 32'h0000_0000));
        vt.push_back(W(8'h1C, 32'hFFFF_FFFF, 4'hF, 2'b11));
        vt.push_back(R(8'h20, 2'b11, 32'h0000_0000));
        vt.push_back(W(8'h24, 32'h0000_0000, 4'hF, 2'b11));
        vt.push_back(R(8'h04, 2'b00, 32'hFFFF_FFFF));
        vt.push_back(W(8'h08, 32'hFFFF_0020, 4'hF, 2'b00));
        vt.push_back(R(8'h08, 2'b00, 32'h0000_0020));
        vt.push_back(W(8'h08, 32'h0000_AB00, 4'b0010, 2'b00));
        vt.push_back(R(8'h08, 2'b00, 32'h0000_AB20));
        vt.push_back(W(8'h04, 32'h0000_0000, 4'b1000, 2'b00));
        vt.push_back(R(8'h04, 2'b00, 32'h00FF_FFFF));

        // Reset state while ARESETN is low.
        repeat (3) @(posedge clk);
        #1;
        chk("rst_awready", {31'b0, awready}, 32'h0);
        chk("rst_wready", {31'b0, wready}, 32'h0);
        chk("rst_arready", {31'b0, arready}, 32'h0);
        chk("rst_bvalid", {31'b0, bvalid}, 32'h0);
        chk("rst_rvalid", {31'b0, rvalid}, 32'h0);
        chk("rst_rdata", rdata, 32'h0);
        chk("rst_enable", {31'b0, ctrl_enable}, 32'h0);
        chk("rst_soft_rst", {31'b0, ctrl_soft_rst}, 32'h0);
        chk("rst_chan_mask", chan_mask, 32'hFFFF_FFFF);
        chk("rst_sample_div", {16'b0, sample_div}, 32'h1);
        arst_n = 1'b1;
        @(posedge clk); #1;
        chk("rel_awready", {31'b0, awready}, 32'h1);
        chk("rel_wready", {31'b0, wready}, 32'h1);
        chk("rel_arready", {31'b0, arready}, 32'h1);

        for (int i = 0; i < vt.size(); i++) begin
            if (vt[i].is_wr) begin
                axi_write(vt[i].addr, vt[i].data, vt[i].strb, resp);
                chk($sformatf("v%0d_bresp", i), {30'b0, resp}, {30'b0, vt[i].resp});
            end else begin
                axi_read(vt[i].addr, resp, d);
                chk($sformatf("v%0d_rresp", i), {30'b0, resp}, {30'b0, vt[i].resp});
                chk($sformatf("v%0d_rdata", i), d, vt[i].rdata);
            end
        end
        chk("port_sample_div", {16'b0, sample_div}, 32'h0000_AB20);
        chk("port_chan_mask", chan_mask, 32'h00FF_FFFF);

        // CTRL write of 0x3: enable latches, soft reset pulses one cycle.
        awaddr = 8'h00; wdata = 32'h3; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0;
        chk("ctrl_soft_rst_hi", {31'b0, ctrl_soft_rst}, 32'h1);
        chk("ctrl_enable_hi", {31'b0, ctrl_enable}, 32'h1);
        chk("ctrl_bvalid", {31'b0, bvalid}, 32'h1);
        bready = 1'b1;
        @(posedge clk); #1;
        chk("ctrl_soft_rst_lo", {31'b0, ctrl_soft_rst}, 32'h0);
        chk("ctrl_bvalid_lo", {31'b0, bvalid}, 32'h0);
        rd_chk("ctrl_rd", 8'h00, 32'h1);
        chk("ctrl_soft_rst_rd", {31'b0, ctrl_soft_rst}, 32'h0);

        // Split channels: AW at cycle 0, W at cycle 5, BREADY from cycle 9.
        awaddr = 8'h14; awvalid = 1'b1; bready = 1'b0;
        @(posedge clk); #1;
        awvalid = 1'b0;
        for (int c = 1; c <= 9; c++) begin
            if (c <= 5) begin
                chk($sformatf("split_c%0d_awready", c), {31'b0, awready}, 32'h0);
                chk($sformatf("split_c%0d_wready", c), {31'b0, wready}, 32'h1);
                chk($sformatf("split_c%0d_bvalid", c), {31'b0, bvalid}, 32'h0);
            end else begin
                chk($sformatf("split_c%0d_awready", c), {31'b0, awready}, 32'h0);
                chk($sformatf("split_c%0d_wready", c), {31'b0, wready}, 32'h0);
                chk($sformatf("split_c%0d_bvalid", c), {31'b0, bvalid}, 32'h1);
                chk($sformatf("split_c%0d_bresp", c), {30'b0, bresp}, 32'h0);
            end
            if (c == 5) begin wdata = 32'hDEAD_BEEF; wstrb = 4'hF; wvalid = 1'b1; end
            if (c == 9) bready = 1'b1;
            @(posedge clk); #1;
            if (c == 5) wvalid = 1'b0;
        end
        chk("split_c10_bvalid", {31'b0, bvalid}, 32'h0);
        chk("split_c10_awready", {31'b0, awready}, 32'h1);
        rd_chk("split_rd", 8'h14, 32'hDEAD_BEEF);

        // Read and write of SCRATCH on the same edge: read sees the old value.
        awaddr = 8'h14; wdata = 32'h0BAD_F00D; wstrb = 4'hF; araddr = 8'h14;
        awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1; bready = 1'b1; rready = 1'b1;
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        chk("same_rvalid", {31'b0, rvalid}, 32'h1);
        chk("same_rdata", rdata, 32'hDEAD_BEEF);
        chk("same_bvalid", {31'b0, bvalid}, 32'h1);
        @(posedge clk); #1;
        rd_chk("same_after", 8'h14, 32'h0BAD_F00D);

        // Overflow sticky and W1C race.
        stat_ovf_pulse = 1'b1;
        @(posedge clk); #1;
        stat_ovf_pulse = 1'b0;
        rd_chk("ovf_set", 8'h0C, 32'h2);
        awaddr = 8'h0C; wdata = 32'h2; wstrb = 4'h1; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
        stat_ovf_pulse = 1'b1;
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0; stat_ovf_pulse = 1'b0;
        @(posedge clk); #1;
        rd_chk("ovf_race", 8'h0C, 32'h2);
        wr_chk("ovf_nostrb", 8'h0C, 32'h2, 4'hE);
        rd_chk("ovf_nostrb", 8'h0C, 32'h2);
        wr_chk("ovf_clr", 8'h0C, 32'h2, 4'h1);
        rd_chk("ovf_clr", 8'h0C, 32'h0);
        stat_busy = 1'b1;
        rd_chk("busy", 8'h0C, 32'h1);
        stat_busy = 1'b0;

        // Reset with a write response pending and a second write waiting.
        awaddr = 8'h14; wdata = 32'h1111_2222; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
        @(posedge clk); #1;
        chk("mid_bvalid", {31'b0, bvalid}, 32'h1);
        wdata = 32'h5555_5555;
        arst_n = 1'b0;
        @(posedge clk); #1;
        chk("mid_rst_bvalid", {31'b0, bvalid}, 32'h0);
        chk("mid_rst_awready", {31'b0, awready}, 32'h0);
        chk("mid_rst_enable", {31'b0, ctrl_enable}, 32'h0);
        chk("mid_rst_chan_mask", chan_mask, 32'hFFFF_FFFF);
        chk("mid_rst_sample_div", {16'b0, sample_div}, 32'h1);
        awvalid = 1'b0; wvalid = 1'b0;
        arst_n = 1'b1;
        @(posedge clk); #1;
        rd_chk("mid_scratch", 8'h14, 32'h0);
        rd_chk("mid_ctrl", 8'h00, 32'h0);
        rd_chk("mid_sdiv", 8'h08, 32'h1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
